bf_loader: RTL and testbench



---
 rtl/bf_pkg.sv | 32 +++
 rtl/bf_decode.sv | 26 ++
 rtl/bf_loader.sv | 142 ++++++++++++++
 tb/tb_bf_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared BF definitions: core opcodes, loader FSM states and the ASCII command set.
package bf_pkg;

    typedef enum logic [2:0] {
        OP_RIGHT = 3'd0,
        OP_LEFT  = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_OUT   = 3'd4,
        OP_IN    = 3'd5,
        OP_JZ    = 3'd6,
        OP_JNZ   = 3'd7
    } bf_op_e;

    typedef enum logic [2:0] {
        ST_ACCEPT,
        ST_SETUP,
        ST_STROBE,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

    localparam logic [7:0] CH_GT    = 8'h3E;  // >
    localparam logic [7:0] CH_LT    = 8'h3C;  // <
    localparam logic [7:0] CH_PLUS  = 8'h2B;  // +
    localparam logic [7:0] CH_MINUS = 8'h2D;  // -
    localparam logic [7:0] CH_DOT   = 8'h2E;  // .
    localparam logic [7:0] CH_COMMA = 8'h2C;  // ,
    localparam logic [7:0] CH_LBRK  = 8'h5B;  // [
    localparam logic [7:0] CH_RBRK  = 8'h5D;  // ]

endpackage

// File: rtl/bf_decode.sv
// ASCII byte to {is_cmd, opcode}; purely combinational.
module bf_decode
    import bf_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_cmd,
    output logic [2:0] op
);

    always_comb begin
        is_cmd = 1'b1;
        op     = OP_RIGHT;
        case (ch)
            CH_GT:    op = OP_RIGHT;
            CH_LT:    op = OP_LEFT;
            CH_PLUS:  op = OP_INC;
            CH_MINUS: op = OP_DEC;
            CH_DOT:   op = OP_OUT;
            CH_COMMA: op = OP_IN;
            CH_LBRK:  op = OP_JZ;
            CH_RBRK:  op = OP_JNZ;
            default:  is_cmd = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_loader.sv
// BF program loader: filters source bytes, writes opcodes into the core program store.
// Optional bracket-balance checking with BF_LOADER_BRACKET_CHECK_EN.
module bf_loader
    import bf_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DEPTH_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    input  logic              src_last,
    output logic              src_ready,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [3:0]        instr_in,
    output logic              instr_write,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err_overflow,
    output logic              err_bracket
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_e  state;
    logic       last_pend;
    logic       is_cmd;
    logic [2:0] op;
    logic       hs;
    logic       full;
    logic       br_err;   // this byte is a bracket that must be rejected
    logic       unbal;    // depth is nonzero (applies once the load ends)

    bf_decode u_decode (
        .ch     (src_data),
        .is_cmd (is_cmd),
        .op     (op)
    );

    assign src_ready = (state == ST_ACCEPT);
    assign hs        = src_valid && src_ready;
    assign full      = (count == CAP);

`ifdef BF_LOADER_BRACKET_CHECK_EN
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] depth_nxt;

    always_comb begin
        br_err    = 1'b0;
        depth_nxt = depth;
        if (is_cmd && op == OP_JZ) begin
            if (depth == '1) br_err = 1'b1;
            else             depth_nxt = depth + 1'b1;
        end else if (is_cmd && op == OP_JNZ) begin
            if (depth == '0) br_err = 1'b1;
            else             depth_nxt = depth - 1'b1;
        end
    end

    assign unbal = (depth != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth       <= '0;
            err_bracket <= 1'b0;
        end else begin
            if (hs && is_cmd && !full && !br_err)
                depth <= depth_nxt;
            if ((hs && is_cmd && !full && br_err) ||
                (hs && !is_cmd && src_last && unbal) ||
                (state == ST_STROBE && last_pend && unbal))
                err_bracket <= 1'b1;
        end
    end
`else
    assign br_err      = 1'b0;
    assign unbal       = 1'b0;
    assign err_bracket = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_ACCEPT;
            last_pend    <= 1'b0;
            instr_addr   <= '0;
            instr_in     <= '0;
            instr_write  <= 1'b0;
            count        <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                ST_ACCEPT: begin
                    if (hs) begin
                        if (!is_cmd) begin
                            if (src_last) begin
                                if (unbal) begin
                                    state <= ST_ERROR;
                                end else begin
                                    done  <= 1'b1;
                                    state <= ST_DONE;
                                end
                            end
                        end else if (full) begin
                            err_overflow <= 1'b1;
                            state        <= ST_ERROR;
                        end else if (br_err) begin
                            state <= ST_ERROR;
                        end else begin
                            instr_addr <= count[ADDR_W-1:0];
                            instr_in   <= {1'b0, op};
                            last_pend  <= src_last;
                            state      <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    instr_write <= 1'b1;
                    state       <= ST_STROBE;
                end
                ST_STROBE: begin
                    instr_write <= 1'b0;
                    count       <= count + ONE;
                    if (!last_pend) begin
                        state <= ST_ACCEPT;
                    end else if (unbal) begin
                        state <= ST_ERROR;
                    end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_DONE;
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_loader.sv
// Scoreboard bench for bf_loader: default-size DUT plus an ADDR_W=2 DUT for overflow.
module tb_bf_loader;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] src_data = 8'h00;
    logic src_last = 1'b0;
    logic vld = 1'b0;
    int   sel = 0;

    always #5 clock = ~clock;

    logic       ready_a, wr_a, done_a, ovf_a, brk_a;
    logic [7:0] addr_a;
    logic [3:0] in_a;
    logic [8:0] count_a;

    logic       ready_b, wr_b, done_b, ovf_b, brk_b;
    logic [1:0] addr_b;
    logic [3:0] in_b;
    logic [2:0] count_b;

    logic valid_a, valid_b;
    assign valid_a = vld && (sel == 0);
    assign valid_b = vld && (sel == 1);

    bf_loader u_dut_a (
        .clock        (clock),
        .reset        (reset),
        .src_data     (src_data),
        .src_valid    (valid_a),
        .src_last     (src_last),
        .src_ready    (ready_a),
        .instr_addr   (addr_a),
        .instr_in     (in_a),
        .instr_write  (wr_a),
        .count        (count_a),
        .done         (done_a),
        .err_overflow (ovf_a),
        .err_bracket  (brk_a)
    );

    bf_loader #(.ADDR_W(2)) u_dut_b (
        .clock        (clock),
        .reset        (reset),
        .src_data     (src_data),
        .src_valid    (valid_b),
        .src_last     (src_last),
        .src_ready    (ready_b),
        .instr_addr   (addr_b),
        .instr_in     (in_b),
        .instr_write  (wr_b),
        .count        (count_b),
        .done         (done_b),
        .err_overflow (ovf_b),
        .err_bracket  (brk_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // expected writes {addr, opcode}
    logic [11:0] qa[$];
    logic [5:0]  qb[$];

    logic [11:0] prev_a = '0;
    logic        prev_wr_a = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_a && !prev_wr_a) begin
                chk("a_setup_stable", int'({addr_a, in_a}), int'(prev_a));
                if (qa.size() == 0) chk("a_unexpected_write", int'(qa.size()), 1);
                else chk("a_write", int'({addr_a, in_a}), int'(qa.pop_front()));
            end
            if (wr_a && prev_wr_a) chk("a_strobe_width", int'(prev_wr_a), 0);
            if (!wr_a && prev_wr_a) chk("a_hold_stable", int'({addr_a, in_a}), int'(prev_a));
        end
        prev_a    <= {addr_a, in_a};
        prev_wr_a <= reset ? 1'b0 : wr_a;
    end

    logic [5:0] prev_b = '0;
    logic       prev_wr_b = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_b && !prev_wr_b) begin
                chk("b_setup_stable", int'({addr_b, in_b}), int'(prev_b));
                if (qb.size() == 0) chk("b_unexpected_write", int'(qb.size()), 1);
                else chk("b_write", int'({addr_b, in_b}), int'(qb.pop_front()));
            end
            if (wr_b && prev_wr_b) chk("b_strobe_width", int'(prev_wr_b), 0);
        end
        prev_b    <= {addr_b, in_b};
        prev_wr_b <= reset ? 1'b0 : wr_b;
    end

    task automatic do_reset();
        @(negedge clock); #2 reset = 1'b1;
        @(negedge clock); #2 reset = 1'b0;
        @(negedge clock);
    endtask

    // called on a negedge; returns on a negedge after the handshake
    task automatic send(input int s, input logic [7:0] b, input logic last, output int waits);
        sel = s; src_data = b; src_last = last; vld = 1'b1; waits = 0;
        while (!(s == 1 ? ready_b : ready_a) && waits < 20) begin
            @(negedge clock);
            waits++;
        end
        if (waits >= 20) chk("handshake_timeout", waits, 0);
        else @(negedge clock);
        vld = 1'b0; src_last = 1'b0;
    endtask

    task automatic send_str(input int s, input string str, input logic last);
        int w;
        logic [7:0] ch;
        for (int i = 0; i < str.len(); i++) begin
            ch = str[i];
            send(s, ch, last && (i == str.len() - 1), w);
        end
    endtask

    task automatic pa(input int addr, input int op);
        qa.push_back({8'(addr), 4'(op)});
    endtask

    initial begin
        int w;
        #1;
        @(negedge clock); @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);

        // reset state
        chk("rst_ready", ready_a, 1);
        chk("rst_addr", addr_a, 0);
        chk("rst_instr", in_a, 0);
        chk("rst_write", wr_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_brk", brk_a, 0);

        // "+[-]."
        pa(0, 2); pa(1, 6); pa(2, 3); pa(3, 7); pa(4, 4);
        send_str(0, "+[-].", 1'b1);
        repeat (4) @(negedge clock);
        chk("p1_count", count_a, 5);
        chk("p1_done", done_a, 1);
        chk("p1_brk", brk_a, 0);
        chk("p1_ready", ready_a, 0);
        chk("p1_drained", qa.size(), 0);

        // "a+\nb-": non-commands filtered, back-to-back acceptance
        do_reset();
        pa(0, 2); pa(1, 3);
        send(0, 8'h61, 1'b0, w); chk("p2_a_wait", w, 0);
        send(0, 8'h2B, 1'b0, w);
        send(0, 8'h0A, 1'b0, w); chk("p2_nl_wait", w, 2);
        send(0, 8'h62, 1'b0, w); chk("p2_b_wait", w, 0);
        send(0, 8'h2D, 1'b1, w);
        repeat (4) @(negedge clock);
        chk("p2_count", count_a, 2);
        chk("p2_done", done_a, 1);
        chk("p2_drained", qa.size(), 0);

        // overflow on a 4-entry store
        do_reset();
        for (int i = 0; i < 4; i++) qb.push_back({2'(i), 4'd2});
        send_str(1, "++++", 1'b0);
        send(1, 8'h2B, 1'b1, w);
        repeat (4) @(negedge clock);
        chk("ovf_flag", ovf_b, 1);
        chk("ovf_ready", ready_b, 0);
        chk("ovf_done", done_b, 0);
        chk("ovf_count", count_b, 4);
        chk("ovf_drained", qb.size(), 0);

        // "]"
        do_reset();
`ifdef BF_LOADER_BRACKET_CHECK_EN
        send_str(0, "]", 1'b1);
        repeat (4) @(negedge clock);
        chk("rb_brk", brk_a, 1);
        chk("rb_done", done_a, 0);
        chk("rb_count", count_a, 0);
`else
        pa(0, 7);
        send_str(0, "]", 1'b1);
        repeat (4) @(negedge clock);
        chk("rb_brk", brk_a, 0);
        chk("rb_done", done_a, 1);
        chk("rb_count", count_a, 1);
`endif
        chk("rb_drained", qa.size(), 0);

        // "[[" with last: both written
        do_reset();
        pa(0, 6); pa(1, 6);
        send_str(0, "[[", 1'b1);
        repeat (4) @(negedge clock);
`ifdef BF_LOADER_BRACKET_CHECK_EN
        chk("ll_brk", brk_a, 1);
        chk("ll_done", done_a, 0);
`else
        chk("ll_brk", brk_a, 0);
        chk("ll_done", done_a, 1);
`endif
        chk("ll_count", count_a, 2);
        chk("ll_drained", qa.size(), 0);

        // reset during SETUP: write abandoned
        do_reset();
        send(0, 8'h2B, 1'b0, w);
        #2 reset = 1'b1;
        #1;
        chk("rs_setup_write", wr_a, 0);
        chk("rs_setup_count", count_a, 0);
        @(negedge clock); #2 reset = 1'b0;
        @(negedge clock);

        // reset during STROBE: strobe drops at once
        pa(0, 2);
        send(0, 8'h2B, 1'b0, w);
        @(negedge clock);
        #2;
        chk("rs_strobe_high", wr_a, 1);
        reset = 1'b1;
        #1;
        chk("rs_strobe_write", wr_a, 0);
        chk("rs_strobe_count", count_a, 0);
        @(negedge clock); #2 reset = 1'b0;
        @(negedge clock);

        pa(0, 2);
        send_str(0, "+", 1'b1);
        repeat (4) @(negedge clock);
        chk("rs_after_count", count_a, 1);
        chk("rs_after_done", done_a, 1);

        // src_valid held while DONE: ignored
        sel = 0; src_data = 8'h2B; vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_ready", ready_a, 0);
        end
        vld = 1'b0;
        repeat (3) @(negedge clock);
        chk("hold_count", count_a, 1);
        chk("hold_drained", qa.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
